// File: rtl/wisc_pkg.sv
// wisc_pkg: shared types and constants for the WISC-S25 front end.
//   PC_W / INSTR_W : program counter and instruction widths
//   OPC_HLT        : opcode field value of the halt instruction
//   fetch_state_t  : fetch stage control states
package wisc_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OPC_HLT = 4'hF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: single-entry hold buffer for an instruction returned while
// decode is stalled.
//   clk, rst     : clock, asynchronous active-high reset
//   capture_i    : load instr_i / pc_i and mark the entry valid
//   clear_i      : entry was delivered, drop it
//   flush_i      : redirect, drop it (wins over capture)
//   instr_i/pc_i : data to capture
//   valid_o, instr_o, pc_o : current entry
module fetch_skid
  import wisc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               capture_i,
  input  logic               clear_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i || clear_i) begin
      valid_d = 1'b0;
    end else if (capture_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the WISC-S25 core. Owns the PC, reads a
// 1-cycle-latency synchronous instruction memory, holds one instruction across
// decode stalls, takes branch redirects and stops after delivering a HLT.
//   clk, rst                  : clock, asynchronous active-high reset
//   stall_i                   : decode cannot accept this cycle
//   redirect_i, redirect_pc_i : taken branch and its target (bit 0 ignored)
//   imem_rd_en_o, imem_addr_o : memory read request
//   imem_data_i               : read data, one cycle after the request
//   instr_valid_o, instr_o, pc_o, pc_plus2_o : instruction to decode
//   halted_o                  : fetch has stopped on a HLT
// Optional build macro FETCH_PERF_EN adds fetch_count_o (deliveries) and
// flush_count_o (redirects that dropped a valid entry), both saturating.
//
// state  | meaning
// RUN    | issuing one request per non-stalled cycle
// HALTED | HLT delivered; no requests until a redirect
module fetch_stage
  import wisc_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_RESET = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               imem_rd_en_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [PC_W-1:0]    pc_plus2_o,
  output logic               halted_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        fetch_count_o,
  output logic [15:0]        flush_count_o
`endif
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               resp_valid_q, resp_valid_d;
  logic [PC_W-1:0]    resp_pc_q, resp_pc_d;

  logic               hold_valid;
  logic [INSTR_W-1:0] hold_instr;
  logic [PC_W-1:0]    hold_pc;

  logic               deliver, halt_hit, issue, capture;
  logic [PC_W-1:0]    fetch_addr;

  fetch_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .capture_i (capture),
    .clear_i   (deliver),
    .flush_i   (redirect_i),
    .instr_i   (imem_data_i),
    .pc_i      (resp_pc_q),
    .valid_o   (hold_valid),
    .instr_o   (hold_instr),
    .pc_o      (hold_pc)
  );

  always_comb begin
    instr_valid_o = hold_valid | resp_valid_q;
    instr_o       = '0;
    pc_o          = '0;
    if (hold_valid) begin
      instr_o = hold_instr;
      pc_o    = hold_pc;
    end else if (resp_valid_q) begin
      instr_o = imem_data_i;
      pc_o    = resp_pc_q;
    end
    pc_plus2_o = pc_o + PC_W'(2);

    // A redirect discards whatever is on the output, so it is never delivered
    // and cannot trigger a halt.
    deliver  = instr_valid_o & ~stall_i & ~redirect_i;
    halt_hit = deliver & (instr_o[INSTR_W-1:INSTR_W-4] == OPC_HLT);
    capture  = resp_valid_q & stall_i & ~redirect_i;

    issue = ((state_q == RUN) | redirect_i) & (~stall_i | redirect_i) & ~halt_hit & ~rst;
    fetch_addr = redirect_i ? (redirect_pc_i & ~PC_W'(1)) : pc_q;

    imem_rd_en_o = issue;
    imem_addr_o  = fetch_addr;

    pc_d         = pc_q;
    resp_valid_d = issue;
    resp_pc_d    = resp_pc_q;
    if (issue) begin
      pc_d      = fetch_addr + PC_W'(2);
      resp_pc_d = fetch_addr;
    end

    state_d = state_q;
    if (redirect_i) begin
      state_d = RUN;
    end else if (halt_hit) begin
      state_d = HALTED;
    end

    halted_o = (state_q == HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= PC_RESET;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [15:0] flush_count_q, flush_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    flush_count_d = flush_count_q;
    if (deliver && (fetch_count_q != '1)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
    if (redirect_i && instr_valid_o && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign fetch_count_o = fetch_count_q;
  assign flush_count_o = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios with literal expectations,
// then randomized stall/redirect/reset traffic against an in-bench model.
module tb_fetch_stage;
  import wisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [15:0] redir_pc = 16'h0000;
  logic        rd_en;
  logic [15:0] addr;
  logic [15:0] imem_data = 16'h0000;
  logic        valid;
  logic [15:0] instr, pc, pc2;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [15:0] flush_count;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .redirect_i    (redir),
    .redirect_pc_i (redir_pc),
    .imem_rd_en_o  (rd_en),
    .imem_addr_o   (addr),
    .imem_data_i   (imem_data),
    .instr_valid_o (valid),
    .instr_o       (instr),
    .pc_o          (pc),
    .pc_plus2_o    (pc2),
    .halted_o      (halted)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count_o (fetch_count),
    .flush_count_o (flush_count)
`endif
  );

  // Instruction memory contents: a fixed word at 0, one optional HLT, and an
  // address-derived pattern elsewhere that never uses the HLT opcode.
  logic        hlt_on = 1'b0;
  logic [15:0] hlt_addr = 16'h0010;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [3:0] op;
    if (a == 16'h0000) return 16'h1234;
    if (hlt_on && a == hlt_addr) return 16'hF000;
    op = a[4:1] ^ a[8:5];
    if (op == 4'hF) op = 4'hE;
    return {op, a[11:0] ^ a[15:4]};
  endfunction

  // Synchronous memory; without a request the bus carries junk, so a stalled
  // instruction survives only if the stage really holds it.
  always @(posedge clk) imem_data <= rd_en ? mem_word(addr) : 16'($urandom);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the single instruction currently shown to decode, the next
  // sequential fetch address, and whether fetch has halted.
  logic [15:0] m_pc = 16'h0000;
  logic        m_valid = 1'b0;
  logic [15:0] m_opc = 16'h0000;
  logic        m_halted = 1'b0;

  function automatic logic hlt_out();
    logic [15:0] w;
    w = mem_word(m_opc);
    return m_valid && !stall && !redir && (w[15:12] == 4'hF);
  endfunction

  task automatic check_model();
    logic e_rd;
    if (rst) begin
      chk("rst_rd_en", rd_en, 0);
      chk("rst_valid", valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_halted", halted, 0);
    end else begin
      chk("valid", valid, m_valid);
      chk("halted", halted, m_halted);
      if (m_valid) begin
        chk("instr", instr, mem_word(m_opc));
        chk("pc", pc, m_opc);
        chk("pc_plus2", pc2, 16'(m_opc + 16'd2));
      end else begin
        chk("instr_idle", instr, 0);
      end
      e_rd = redir || (!stall && !m_halted && !hlt_out());
      chk("rd_en", rd_en, e_rd);
      if (e_rd) chk("addr", addr, redir ? (redir_pc & 16'hFFFE) : m_pc);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_pc = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    end else if (redir) begin
      m_opc = redir_pc & 16'hFFFE;
      m_pc = m_opc + 16'd2;
      m_valid = 1'b1;
      m_halted = 1'b0;
    end else if (stall) begin
      // output and fetch address frozen
    end else if (hlt_out()) begin
      m_halted = 1'b1;
      m_valid = 1'b0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else begin
      m_opc = m_pc;
      m_valid = 1'b1;
      m_pc = m_pc + 16'd2;
    end
  endtask

  // Apply inputs mid-cycle, check the settled outputs, advance the model.
  // Caller-side literal checks after a tick see that same cycle's outputs.
  task automatic tick(input logic st, input logic rd, input logic [15:0] tgt, input logic r);
    @(negedge clk);
    stall = st; redir = rd; redir_pc = tgt; rst = r;
    #1;
    check_model();
    model_step();
  endtask

  initial begin
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
`ifdef FETCH_PERF_EN
    chk("rst_fetch_count", fetch_count, 0);
    chk("rst_flush_count", flush_count, 0);
`endif

    // Reset release and streaming
    tick(0, 0, 0, 0);
    chk("first_req", rd_en, 1);
    chk("first_addr", addr, 16'h0000);
    tick(0, 0, 0, 0);
    chk("second_addr", addr, 16'h0002);
    chk("first_valid", valid, 1);
    chk("first_instr", instr, 16'h1234);
    chk("first_pc", pc, 16'h0000);
    chk("first_pc2", pc2, 16'h0002);
    tick(0, 0, 0, 0);
    chk("third_addr", addr, 16'h0004);

    // 3-cycle stall with 0x0004 on the output
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0);
      chk("stall_no_req", rd_en, 0);
      chk("stall_pc", pc, 16'h0004);
    end
    tick(0, 0, 0, 0);
    chk("release_addr", addr, 16'h0006);
    chk("release_pc", pc, 16'h0004);
    tick(0, 0, 0, 0);
    chk("after_release_pc", pc, 16'h0006);

    // Redirect with a response in flight
    tick(0, 1, 16'h0041, 0);
    chk("redir_req", rd_en, 1);
    chk("redir_addr", addr, 16'h0040);
    tick(0, 0, 0, 0);
    chk("redir_pc", pc, 16'h0040);

    // HLT at 0x0010
    hlt_on = 1'b1; hlt_addr = 16'h0010;
    tick(0, 1, 16'h000C, 0);
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0, 0);
      if (valid && pc == 16'h0010) break;
    end
    chk("hlt_seen_pc", pc, 16'h0010);
    chk("hlt_instr", instr, 16'hF000);
    chk("hlt_no_req", rd_en, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0);
      chk("halted_lit", halted, 1);
      chk("halted_invalid", valid, 0);
      chk("halted_no_req", rd_en, 0);
    end
    tick(0, 1, 16'h0020, 0);
    chk("resume_req", rd_en, 1);
    chk("resume_addr", addr, 16'h0020);
    tick(0, 0, 0, 0);
    chk("resume_halted", halted, 0);
    chk("resume_pc", pc, 16'h0020);

    // PC wrap
    tick(0, 1, 16'hFFFC, 0);
    tick(0, 0, 0, 0);
    chk("wrap_addr_fffe", addr, 16'hFFFE);
    tick(0, 0, 0, 0);
    chk("wrap_pc", pc, 16'hFFFE);
    chk("wrap_pc2", pc2, 16'h0000);
    chk("wrap_addr", addr, 16'h0000);

    // Reset mid-stall with a held instruction
    tick(0, 1, 16'h0100, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("held_pc", pc, 16'h0100);
    tick(1, 0, 0, 1);
    chk("midrst_valid", valid, 0);
    chk("midrst_rd_en", rd_en, 0);
`ifdef FETCH_PERF_EN
    chk("midrst_fetch_count", fetch_count, 0);
    chk("midrst_flush_count", flush_count, 0);
`endif
    tick(0, 0, 0, 0);
    chk("restart_addr", addr, 16'h0000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, rd, st;
      logic [15:0] tgt;
      r  = ($urandom_range(0, 99) == 0);
      st = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 8);
      tgt = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h7F));
      if (r) begin
        // memory contents only change while everything is being discarded
        @(negedge clk);
        rst = 1'b1;
        hlt_addr = 16'($urandom_range(1, 31)) << 1;
      end
      tick(st, rd, tgt, r);
    end

    tick(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
